// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32 instruction-fetch stage with IF/ID pipeline register
//
// Keeps the PC and issues one instruction-memory request at a time. Each
// returned word is presented to decode as {ID_pc, ID_instr, ID_valid}. A
// one-entry hold buffer catches a response that arrives while decode is
// stalled. While that buffer is full, no new request is issued.
//
// Optional feature macro: FETCH_PERF_EN adds the perf_fetched and
// perf_killed counters and their output ports.
//
// Ports:
//   clk          in   clock, all state updates on the rising edge
//   rst          in   synchronous active-high reset
//   stall        in   hold IF/ID contents
//   flush        in   squash IF/ID and in-flight fetch, restart at redirect_pc
//   redirect_pc  in   restart address, used only with flush
//   imem_req     out  fetch request (memory always accepts)
//   imem_addr    out  fetch address, valid with imem_req
//   imem_rvalid  in   response strobe
//   imem_rdata   in   instruction word, valid with imem_rvalid
//   ID_pc        out  PC of the instruction in IF/ID
//   ID_instr     out  instruction in IF/ID, NOP_INSTR when not valid
//   ID_valid     out  IF/ID holds a real instruction
//   perf_fetched out  (FETCH_PERF_EN) responses taken into IF/ID or hold buffer
//   perf_killed  out  (FETCH_PERF_EN) responses discarded

module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ID_pc,
    output logic [31:0] ID_instr,
`ifdef FETCH_PERF_EN
    output logic        ID_valid,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_killed
`else
    output logic        ID_valid
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_KILL = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] r_req_pc;
    logic        r_hold_valid;
    logic [31:0] r_hold_pc;
    logic [31:0] r_hold_instr;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_instr;
    logic        r_id_valid;

    logic        w_resp_ok;
    logic        w_resp_kill;
    logic        w_issue;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request issue and next state
    always_comb begin
        w_resp_ok   = 1'b0;
        w_resp_kill = 1'b0;
        w_issue     = 1'b0;
        w_state_nxt = r_state;

        w_resp_ok   = (r_state == S_WAIT) && imem_rvalid;
        w_resp_kill = (r_state == S_KILL) && imem_rvalid;

        // A full hold buffer blocks issue. A stalled response in WAIT is
        // parked in the buffer rather than followed by a new request.
        w_issue = !rst && !flush && !r_hold_valid &&
                  ((r_state == S_IDLE) || (w_resp_ok && !stall) || w_resp_kill);

        if (flush) begin
            // A request still in flight must have its response swallowed.
            if ((r_state != S_IDLE) && !imem_rvalid) begin
                w_state_nxt = S_KILL;
            end else begin
                w_state_nxt = S_IDLE;
            end
        end else if (w_issue) begin
            w_state_nxt = S_WAIT;
        end else if (w_resp_ok || w_resp_kill) begin
            w_state_nxt = S_IDLE;
        end
    end

    assign imem_req  = w_issue;
    assign imem_addr = r_pc;

    // PC, hold buffer and IF/ID register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_req_pc     <= RESET_PC;
            r_hold_valid <= 1'b0;
            r_hold_pc    <= 32'h0;
            r_hold_instr <= NOP_INSTR;
            r_id_pc      <= 32'h0;
            r_id_instr   <= NOP_INSTR;
            r_id_valid   <= 1'b0;
        end else begin
            if (flush) begin
                r_pc <= redirect_pc;
            end else if (w_issue) begin
                r_req_pc <= r_pc;
                r_pc     <= r_pc + 32'd4;
            end

            if (flush) begin
                r_hold_valid <= 1'b0;
            end else if (w_resp_ok && stall) begin
                r_hold_valid <= 1'b1;
                r_hold_pc    <= r_req_pc;
                r_hold_instr <= imem_rdata;
            end else if (!stall && r_hold_valid) begin
                r_hold_valid <= 1'b0;
            end

            // ID_pc is left as-is on flush and bubbles; only valid/instr change.
            if (flush) begin
                r_id_valid <= 1'b0;
                r_id_instr <= NOP_INSTR;
            end else if (stall) begin
                r_id_valid <= r_id_valid;
            end else if (r_hold_valid) begin
                r_id_valid <= 1'b1;
                r_id_pc    <= r_hold_pc;
                r_id_instr <= r_hold_instr;
            end else if (w_resp_ok) begin
                r_id_valid <= 1'b1;
                r_id_pc    <= r_req_pc;
                r_id_instr <= imem_rdata;
            end else begin
                r_id_valid <= 1'b0;
                r_id_instr <= NOP_INSTR;
            end
        end
    end

    assign ID_pc    = r_id_pc;
    assign ID_instr = r_id_instr;
    assign ID_valid = r_id_valid;

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_killed;

    // A response in WAIT is only lost when a flush lands in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetched <= 32'h0;
            r_perf_killed  <= 32'h0;
        end else begin
            if (w_resp_ok && !flush) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (w_resp_kill || (w_resp_ok && flush)) begin
                r_perf_killed <= r_perf_killed + 32'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_killed  = r_perf_killed;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage

module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] ID_pc;
    logic [31:0] ID_instr;
    logic        ID_valid;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_killed;
`endif

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .ID_pc       (ID_pc),
        .ID_instr    (ID_instr),
`ifdef FETCH_PERF_EN
        .ID_valid    (ID_valid),
        .perf_fetched(perf_fetched),
        .perf_killed (perf_killed)
`else
        .ID_valid    (ID_valid)
`endif
    );

    int checks = 0;
    int errors = 0;

    // memory model: one pending request, response after mem_cnt+1 cycles
    bit          mem_busy  = 0;
    bit          mem_stale = 0;
    int          mem_cnt   = 0;
    int          mem_lat   = 1;
    bit          mem_rand  = 0;
    logic [31:0] mem_addr  = 32'h0;

    // scoreboard: expected next request address and next delivered PC
    logic [31:0] exp_req    = RESET_PC;
    logic [31:0] exp_id_pc  = RESET_PC;
    int          delivered  = 0;
    logic [31:0] exp_fetched = 32'h0;
    logic [31:0] exp_killed  = 32'h0;

    logic        s_req;
    logic [31:0] s_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_mem();
        imem_rvalid = mem_busy && (mem_cnt == 0);
        imem_rdata  = imem_rvalid ? (mem_addr ^ KEY) : 32'hDEAD_BEEF;
    endtask

    // One clock cycle: sample combinational outputs before the edge, advance
    // the memory model at the edge, then check IF/ID against the rules.
    task automatic step();
        logic        rst_s, stall_s, flush_s, rv_s, pv;
        logic [31:0] redir_s, ppc, pinstr;
        #1;
        rst_s   = rst;
        stall_s = stall;
        flush_s = flush;
        redir_s = redirect_pc;
        rv_s    = imem_rvalid;
        s_req   = imem_req;
        s_addr  = imem_addr;
        pv      = ID_valid;
        ppc     = ID_pc;
        pinstr  = ID_instr;

        if (rst_s || flush_s) begin
            chk("req_blocked", {31'b0, s_req}, 32'd0);
        end else if (s_req) begin
            chk("req_addr", s_addr, exp_req);
            chk("req_while_busy", {31'b0, mem_busy && !rv_s}, 32'd0);
            exp_req = exp_req + 32'd4;
        end

        @(posedge clk);
        #1;

        if (rst_s) begin
            mem_busy    = 0;
            mem_stale   = 0;
            exp_fetched = 32'h0;
            exp_killed  = 32'h0;
        end else begin
            if (rv_s) begin
                if (mem_stale || flush_s) exp_killed = exp_killed + 32'd1;
                else                      exp_fetched = exp_fetched + 32'd1;
                mem_busy = 0;
            end else if (mem_busy) begin
                mem_cnt--;
            end
            if (flush_s && mem_busy) mem_stale = 1;
            if (s_req) begin
                mem_busy  = 1;
                mem_stale = 0;
                mem_addr  = s_addr;
                mem_cnt   = mem_rand ? int'($urandom_range(0, 3)) : mem_lat - 1;
            end
        end
        drive_mem();

        if (rst_s) begin
            chk("rst_valid", {31'b0, ID_valid}, 32'd0);
            chk("rst_instr", ID_instr, NOP);
            chk("rst_pc", ID_pc, 32'h0);
            exp_req   = RESET_PC;
            exp_id_pc = RESET_PC;
        end else if (flush_s) begin
            chk("flush_valid", {31'b0, ID_valid}, 32'd0);
            chk("flush_instr", ID_instr, NOP);
            chk("flush_pc_kept", ID_pc, ppc);
            exp_req   = redir_s;
            exp_id_pc = redir_s;
        end else if (stall_s) begin
            chk("stall_valid", {31'b0, ID_valid}, {31'b0, pv});
            chk("stall_pc", ID_pc, ppc);
            chk("stall_instr", ID_instr, pinstr);
        end else if (ID_valid) begin
            chk("id_pc_order", ID_pc, exp_id_pc);
            chk("id_instr", ID_instr, exp_id_pc ^ KEY);
            exp_id_pc = exp_id_pc + 32'd4;
            delivered++;
        end else begin
            chk("bubble_instr", ID_instr, NOP);
        end
`ifdef FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, exp_fetched);
        chk("perf_killed", perf_killed, exp_killed);
`endif
    endtask

    typedef struct {
        logic        rst;
        logic        stall;
        logic        flush;
        logic [31:0] redir;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    vec_t tbl [22];

    initial begin
        // rst stall flush redir | req addr | valid pc   (1-cycle memory)
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h4,         1'b1, 32'h0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h8,         1'b1, 32'h4};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h4};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h4};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h4};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h8};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hC,         1'b0, 32'h0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h10,        1'b1, 32'hC};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 32'h100,       1'b0, 32'h0,         1'b0, 32'h0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h100,       1'b0, 32'h0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h104,       1'b1, 32'h100};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,         1'b0, 32'h0};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         1'b1, 32'hFFFF_FFFC};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h4,         1'b1, 32'h0};
        tbl[18] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0};
        tbl[19] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
        tbl[20] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0};
        tbl[21] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h4,         1'b1, 32'h0};

        rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_pc = 32'h0;
        drive_mem();

        // table-driven vectors
        mem_rand = 0;
        mem_lat  = 1;
        for (int i = 0; i < 22; i++) begin
            rst         = tbl[i].rst;
            stall       = tbl[i].stall;
            flush       = tbl[i].flush;
            redirect_pc = tbl[i].redir;
            step();
            chk($sformatf("tbl%0d_req", i), {31'b0, s_req}, {31'b0, tbl[i].req});
            if (tbl[i].req) chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].addr);
            chk($sformatf("tbl%0d_valid", i), {31'b0, ID_valid}, {31'b0, tbl[i].valid});
            if (tbl[i].valid) begin
                chk($sformatf("tbl%0d_pc", i), ID_pc, tbl[i].pc);
                chk($sformatf("tbl%0d_instr", i), ID_instr, tbl[i].pc ^ KEY);
            end else begin
                chk($sformatf("tbl%0d_nop", i), ID_instr, NOP);
            end
        end
        stall = 1'b0; flush = 1'b0;

        // flush while a 3-cycle request is outstanding: stale response dropped
        mem_lat = 3;
        rst = 1'b1; step(); rst = 1'b0;
        step();
        chk("kill_req0", {31'b0, s_req}, 32'd1);
        chk("kill_addr0", s_addr, RESET_PC);
        flush = 1'b1; redirect_pc = 32'h100;
        step();
        flush = 1'b0;
        chk("kill_flush_noreq", {31'b0, s_req}, 32'd0);
        step();
        chk("kill_wait_noreq", {31'b0, s_req}, 32'd0);
        chk("kill_wait_valid", {31'b0, ID_valid}, 32'd0);
        step();
        chk("kill_reissue_req", {31'b0, s_req}, 32'd1);
        chk("kill_reissue_addr", s_addr, 32'h100);
        chk("kill_dropped_valid", {31'b0, ID_valid}, 32'd0);
`ifdef FETCH_PERF_EN
        chk("kill_perf_killed", perf_killed, 32'd1);
`endif
        begin
            int n;
            n = 0;
            while (!ID_valid && n < 10) begin
                step();
                n++;
            end
            chk("kill_deliver_timeout", {31'b0, ID_valid}, 32'd1);
            chk("kill_deliver_pc", ID_pc, 32'h100);
        end

        // randomized traffic against the scoreboard
        mem_rand = 1;
        rst = 1'b1; step(); rst = 1'b0;
        delivered = 0;
        for (int c = 0; c < 3000; c++) begin
            rst   = ($urandom_range(0, 199) == 0);
            stall = ($urandom_range(0, 99) < 25);
            flush = ($urandom_range(0, 99) < 6);
            if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF4;
            else                           redirect_pc = $urandom() & 32'hFFFF_FFFC;
            step();
        end
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        chk("liveness", {31'b0, (delivered >= 200)}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
